// File: rtl/mix_columns_seq_pkg.sv
// Shared AES datapath definitions: state geometry and the MixColumns sequencer FSM encoding.
package mix_columns_seq_pkg;

  localparam int STATE_W  = 128;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;

  // Sequencer states; the round controller reuses this encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mixseq_state_t;

endpackage

// File: rtl/mix_columns_seq_msc.sv
// MixSingleColumn: combinational GF(2^8) mix of one 32-bit AES column.
// Byte 0 of the column is the MSB.
module mix_single_column
  import mix_columns_seq_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  output logic [COL_W-1:0] o_col
);

  // Multiply by x (i.e. {02}) in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    logic [7:0] r;
    if (a[7]) begin
      r = {a[6:0], 1'b0} ^ 8'h1b;
    end else begin
      r = {a[6:0], 1'b0};
    end
    return r;
  endfunction

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  // Circulant matrix {02,03,01,01}; {03}*a is written as xtime(a)^a.
  always_comb begin
    o_col[31:24] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    o_col[23:16] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    o_col[15:8]  = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    o_col[7:0]   = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Area-reduced MixColumns: one MixSingleColumn instance reused over the four
// columns of a buffered state, one column per cycle, with valid/ready on both sides.
module mix_columns_seq #(
  parameter int NUM_COLS = 4,
  parameter int COL_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_COLS*COL_W-1:0] in_state,
  input  logic                  in_bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_COLS*COL_W-1:0] out_state,
  output logic                  busy
);

  import mix_columns_seq_pkg::mixseq_state_t;
  import mix_columns_seq_pkg::IDLE;
  import mix_columns_seq_pkg::RUN;
  import mix_columns_seq_pkg::DONE;

  localparam int SW  = NUM_COLS * COL_W;
  localparam int CIW = $clog2(NUM_COLS);
  localparam logic [CIW-1:0] LAST_COL = CIW'(NUM_COLS - 1);

  mixseq_state_t    r_state;
  mixseq_state_t    w_state_nxt;
  logic [CIW-1:0]   r_col_idx;
  logic [SW-1:0]    r_buf;
  logic [SW-1:0]    w_buf_wb;
  logic [COL_W-1:0] w_col_in;
  logic [COL_W-1:0] w_col_out;
  logic             w_accept;

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_state = r_buf;

  // Column read mux: column 0 sits in the top 32 bits.
  assign w_col_in = r_buf[SW-1-COL_W*int'(r_col_idx) -: COL_W];

  mix_single_column u_msc (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  // Write-back decode: replace only the column currently being mixed.
  always_comb begin
    w_buf_wb = r_buf;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (r_col_idx == CIW'(c)) begin
        w_buf_wb[SW-1-COL_W*c -: COL_W] = w_col_out;
      end else begin
        w_buf_wb[SW-1-COL_W*c -: COL_W] = r_buf[SW-1-COL_W*c -: COL_W];
      end
    end
  end

  // Next-state logic; a DONE handshake with a new input goes straight to RUN/DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = in_bypass ? DONE : RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (r_col_idx == LAST_COL) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (out_ready & in_valid) begin
          w_state_nxt = in_bypass ? DONE : RUN;
        end else if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // State buffer and column counter: load on accept, write back one column per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf     <= {SW{1'b0}};
      r_col_idx <= {CIW{1'b0}};
    end else if (w_accept) begin
      r_buf     <= in_state;
      r_col_idx <= {CIW{1'b0}};
    end else if (r_state == RUN) begin
      r_buf     <= w_buf_wb;
      r_col_idx <= r_col_idx + CIW'(1);
    end else begin
      r_buf     <= r_buf;
      r_col_idx <= r_col_idx;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: vector table, multi-cycle corner
// sequences and a randomized stream against a GF(2^8) MixColumns reference.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain GF(2^8) multiply and the AES MixColumns matrix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] st, input logic byp);
    logic [127:0] r = 128'h0;
    logic [7:0]   acc;
    logic [7:0]   coef;
    if (byp) return st;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          case ((k - row + 4) % 4)
            0: coef = 8'h02;
            1: coef = 8'h03;
            default: coef = 8'h01;
          endcase
          acc = acc ^ gmul(coef, st[127-32*c-8*k -: 8]);
        end
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transaction from IDLE: accept, count edges until out_valid, then consume.
  task automatic xfer(input logic [127:0] st, input logic byp,
                      output logic [127:0] res, output int lat);
    in_state = st; in_bypass = byp; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_state = ~st; in_bypass = ~byp;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = out_state;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [127:0] st;
    logic         byp;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[6];
  logic [127:0] res, hold, ea, eb, e;
  logic [127:0] q[$];
  int lat, t, sent, rx, cyc;
  logic acc_s, done_s;

  initial begin
    vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 128'h00112233_44556677_8899aabb_ccddeeff};
    vecs[2] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
    vecs[3] = '{128'h0, 1'b0, 128'h0};
    vecs[4] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 1'b0, 128'hffffffff_ffffffff_ffffffff_ffffffff};
    vecs[5] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1, 128'hdb135345_f20a225c_01010101_c6c6c6c6};

    rst_n = 1'b0; in_valid = 1'b0; in_state = 128'h0; in_bypass = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
    chk("rst_out_state", out_state, 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: known-answer vectors, cross-checked against the reference model.
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].st, vecs[i].byp, res, lat);
      chk($sformatf("vec%0d_data", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_model", i), res, ref_model(vecs[i].st, vecs[i].byp));
      // Mix: four RUN cycles after the accept edge; bypass: DONE straight after it.
      chk($sformatf("vec%0d_latency", i), 128'(lat), vecs[i].byp ? 128'd0 : 128'd4);
      chk($sformatf("vec%0d_idle", i), {127'h0, busy}, 128'h0);
    end

    // Backpressure: DONE holds output and blocks input for 10 stalled cycles.
    e = ref_model(vecs[2].st, 1'b0);
    in_state = vecs[2].st; in_bypass = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    for (int i = 0; i < 10; i++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1; in_bypass = i[0];
      @(posedge clk); #1;
      chk("bp_out_valid", {127'h0, out_valid}, 128'h1);
      chk("bp_out_state", out_state, e);
      chk("bp_in_ready", {127'h0, in_ready}, 128'h0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_release", {127'h0, out_valid}, 128'h0);

    // Back-to-back: second accept shares the edge with the first output handshake.
    ea = ref_model(vecs[0].st, 1'b0);
    eb = ref_model(vecs[2].st, 1'b0);
    in_state = vecs[0].st; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_state = vecs[2].st;
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("b2b_lat_a", 128'(t), 128'd4);
    chk("b2b_data_a", out_state, ea);
    chk("b2b_in_ready", {127'h0, in_ready}, 128'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("b2b_gap_b", 128'(t + 1), 128'd5);
    chk("b2b_data_b", out_state, eb);
    @(posedge clk); #1; out_ready = 1'b0;
    chk("b2b_idle", {127'h0, busy}, 128'h0);

    // Reset while column 2 is being mixed.
    in_state = vecs[0].st; in_bypass = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("mrst_busy", {127'h0, busy}, 128'h0);
    chk("mrst_in_ready", {127'h0, in_ready}, 128'h1);
    chk("mrst_out_state", out_state, 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(vecs[2].st, 1'b0, res, lat);
    chk("mrst_fresh", res, vecs[2].exp);
    chk("mrst_fresh_lat", 128'(lat), 128'd4);

    // Random stream with stalls; scoreboard queue catches drops and duplicates.
    sent = 0; rx = 0; cyc = 0;
    while (rx < 1000 && cyc < 60000) begin
      @(negedge clk);
      acc_s  = in_valid && in_ready;
      done_s = out_valid && out_ready;
      if (done_s) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rand_dup: got %h, expected no output", out_state);
        end else begin
          e = q.pop_front();
          chk("rand_data", out_state, e);
        end
        rx++;
      end
      if (acc_s) begin
        q.push_back(ref_model(in_state, in_bypass));
        sent++;
      end
      @(posedge clk); #1; cyc++;
      if (!in_valid || acc_s) begin
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = $urandom_range(0, 1) == 1;
        in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      end
      out_ready = $urandom_range(0, 2) != 0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_received", 128'(rx), 128'd1000);
    chk("rand_sent", 128'(sent), 128'd1000);
    chk("rand_queue_empty", 128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
